// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the sized data memory.
package dmem_pkg;

  // Access size encodings carried on req_size.
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_R = 2'd3;

  // Controller states: INIT sweeps the array to zero, RUN serves requests.
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Byte-lane enables for an aligned access of the given size at a byte offset.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      SZ_B:    be = 4'b0001 << off;
      SZ_H:    be = 4'b0011 << off;
      SZ_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dmem_ext.sv
// Lane select and sign/zero extension of a 32-bit memory word for loads.
module dmem_ext
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Pick the addressed byte/half, then extend from its top bit unless unsigned.
  always_comb begin
    lane_b = 8'h00;
    lane_h = 16'h0000;
    data   = 32'h0000_0000;
    case (off)
      2'd0:    lane_b = word[7:0];
      2'd1:    lane_b = word[15:8];
      2'd2:    lane_b = word[23:16];
      default: lane_b = word[31:24];
    endcase
    lane_h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_B:    data = {{24{~uns & lane_b[7]}}, lane_b};
      SZ_H:    data = {{16{~uns & lane_h[15]}}, lane_h};
      SZ_W:    data = word;
      default: data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/dmem_sized.sv
// Sized data memory for the MEM stage: byte/half/word access, zero sweep
// after reset, valid/ready request port and fixed-latency in-order responses.
//
// Handshake: a request transfers on a clk edge where req_valid & req_ready;
// req_ready is high in RUN only. Responses have no back-pressure: rsp_valid
// is a one-cycle strobe, RD_LAT cycles after the accept edge, one per request.
module dmem_sized
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = $clog2(DEPTH);
  // Any address bit at or above log2(DEPTH)+2 puts the access out of range.
  localparam logic [ADDR_W-1:0] HI_MASK = ~ADDR_W'(DEPTH * 4 - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [0:0]       state;   // controller state, visible for checkers
  logic [IDX_W-1:0] cnt;
  logic             accept;
  logic             fault;
  logic [IDX_W-1:0] idx;
  logic [1:0]       off;
  logic [3:0]       be;
  logic [31:0]      wdata_rep;

  // Stage 1: captured at the accept edge.
  logic        s1_valid;
  logic        s1_err;
  logic        s1_load;
  logic [31:0] s1_word;
  logic [1:0]  s1_off;
  logic [1:0]  s1_size;
  logic        s1_uns;
  logic [31:0] ext_data;
  logic [31:0] s1_rdata;
  logic        s1_rsp_err;

  assign req_ready = (state == ST_RUN);
  assign accept    = req_valid & req_ready & ~rst;
  assign idx       = req_addr[IDX_W+1:2];
  assign off       = req_addr[1:0];
  assign be        = byte_en(req_size, off);

  // Decode fault conditions and replicate store data across byte lanes.
  always_comb begin
    fault = (req_size == SZ_R)
          | ((req_size == SZ_H) & off[0])
          | ((req_size == SZ_W) & (off != 2'd0))
          | (|(req_addr & HI_MASK));
    case (req_size)
      SZ_B:    wdata_rep = {4{req_wdata[7:0]}};
      SZ_H:    wdata_rep = {2{req_wdata[15:0]}};
      default: wdata_rep = req_wdata;
    endcase
  end

  // Controller: sweep every word once after reset, then serve forever.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else if (state == ST_INIT) begin
      if (cnt == IDX_W'(DEPTH - 1)) state <= ST_RUN;
      cnt <= cnt + 1'b1;
    end
  end

  // Array writes: zero sweep in INIT, lane-masked store commit in RUN.
  always_ff @(posedge clk) begin
    if (!rst && state == ST_INIT) begin
      mem[cnt] <= '0;
    end else if (accept && req_write && !fault) begin
      for (int l = 0; l < 4; l++) begin
        if (be[l]) mem[idx][8*l +: 8] <= wdata_rep[8*l +: 8];
      end
    end
  end

  // Response stage 1: read the word and remember how to extend it.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
      s1_load  <= 1'b0;
      s1_word  <= '0;
      s1_off   <= '0;
      s1_size  <= '0;
      s1_uns   <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_err  <= fault;
        s1_load <= ~req_write;
        s1_word <= mem[idx];
        s1_off  <= off;
        s1_size <= req_size;
        s1_uns  <= req_unsigned;
      end
    end
  end

  dmem_ext u_ext (
    .word (s1_word),
    .off  (s1_off),
    .size (s1_size),
    .uns  (s1_uns),
    .data (ext_data)
  );

  // Data and error are forced to zero outside the strobe, for stores and faults.
  assign s1_rdata   = (s1_valid && s1_load && !s1_err) ? ext_data : 32'h0;
  assign s1_rsp_err = s1_valid & s1_err;

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic        s2_valid;
      logic        s2_err;
      logic [31:0] s2_rdata;

      // Response stage 2: register extended data and error flag.
      always_ff @(posedge clk) begin
        if (rst) begin
          s2_valid <= 1'b0;
          s2_err   <= 1'b0;
          s2_rdata <= '0;
        end else begin
          s2_valid <= s1_valid;
          s2_err   <= s1_rsp_err;
          s2_rdata <= s1_rdata;
        end
      end

      assign rsp_valid = s2_valid;
      assign rsp_err   = s2_err;
      assign rsp_rdata = s2_rdata;
    end else begin : g_lat1
      assign rsp_valid = s1_valid;
      assign rsp_err   = s1_rsp_err;
      assign rsp_rdata = s1_rdata;
    end
  endgenerate

endmodule

// File: tb/tb_dmem_sized.sv
// Directed bench for dmem_sized: two instances (RD_LAT 1 and 2) share inputs.
module tb_dmem_sized;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        ready1, ready2;
  logic        rsp_valid1, rsp_valid2;
  logic [31:0] rsp_rdata1, rsp_rdata2;
  logic        rsp_err1, rsp_err2;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Expected responses in issue order, with the edge each request was accepted.
  logic [31:0] exp_q[$];
  logic        exp_err_q[$];
  int          exp_acc_q[$];
  string       exp_tag_q[$];

  // Observed responses per instance, with the edge that launched them.
  logic [31:0] o1_d[$], o2_d[$];
  logic        o1_e[$], o2_e[$];
  int          o1_c[$], o2_c[$];

  // Clock and edge counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_sized #(.DATA_W(32), .DEPTH(32), .ADDR_W(32), .RD_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready1),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
  );

  dmem_sized #(.DATA_W(32), .DEPTH(32), .ADDR_W(32), .RD_LAT(2)) u_lat2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready2),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .rsp_err(rsp_err2)
  );

  // Response monitors, sampling mid-cycle.
  always @(negedge clk) begin
    if (rsp_valid1) begin
      o1_d.push_back(rsp_rdata1); o1_e.push_back(rsp_err1); o1_c.push_back(cyc);
    end
    if (rsp_valid2) begin
      o2_d.push_back(rsp_rdata2); o2_e.push_back(rsp_err2); o2_c.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input string tag, input logic w, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_d, input logic exp_e);
    req_valid    = 1'b1;
    req_write    = w;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    step();
    exp_q.push_back(exp_d);
    exp_err_q.push_back(exp_e);
    exp_acc_q.push_back(cyc);
    exp_tag_q.push_back(tag);
  endtask

  // Let the pipes empty, then match every expected response on both instances.
  task automatic drain();
    logic [31:0] d;
    logic        e;
    int          a;
    string       t;
    req_valid = 1'b0;
    repeat (4) step();
    while (exp_q.size() > 0) begin
      d = exp_q.pop_front(); e = exp_err_q.pop_front();
      a = exp_acc_q.pop_front(); t = exp_tag_q.pop_front();
      check({t, " present lat1"}, 32'(o1_d.size() != 0), 32'd1);
      if (o1_d.size() != 0) begin
        check({t, " data lat1"}, o1_d.pop_front(), d);
        check({t, " err lat1"}, 32'(o1_e.pop_front()), 32'(e));
        check({t, " timing lat1"}, 32'(o1_c.pop_front()), 32'(a));
      end
      check({t, " present lat2"}, 32'(o2_d.size() != 0), 32'd1);
      if (o2_d.size() != 0) begin
        check({t, " data lat2"}, o2_d.pop_front(), d);
        check({t, " err lat2"}, 32'(o2_e.pop_front()), 32'(e));
        check({t, " timing lat2"}, 32'(o2_c.pop_front()), 32'(a + 1));
      end
    end
    check("extra responses lat1", 32'(o1_d.size()), 32'd0);
    check("extra responses lat2", 32'(o2_d.size()), 32'd0);
    o1_d.delete(); o1_e.delete(); o1_c.delete();
    o2_d.delete(); o2_e.delete(); o2_c.delete();
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready1 && n < 100) begin
      step();
      n++;
    end
    check("ready after init", 32'(ready1), 32'd1);
    check("ready after init lat2", 32'(ready2), 32'd1);
  endtask

  initial begin
    int n0;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = SZ_W;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    step(); step();

    // Reset values.
    check("reset ready lat1", 32'(ready1), 32'd0);
    check("reset ready lat2", 32'(ready2), 32'd0);
    check("reset rsp_valid lat1", 32'(rsp_valid1), 32'd0);
    check("reset rsp_valid lat2", 32'(rsp_valid2), 32'd0);
    check("reset rsp_err lat1", 32'(rsp_err1), 32'd0);
    check("reset rsp_err lat2", 32'(rsp_err2), 32'd0);
    check("reset rsp_rdata lat1", rsp_rdata1, 32'h0);
    check("reset rsp_rdata lat2", rsp_rdata2, 32'h0);

    // Sweep length with a request held pending, then load the last word.
    rst = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_size = SZ_W; req_addr = 32'h7C;
    n0 = 0;
    while (!ready1 && n0 < 100) begin
      n0++;
      step();
    end
    check("init cycles", 32'(n0), 32'd32);
    check("ready lat2 with lat1", 32'(ready2), 32'd1);
    issue("ld w 7c", 1'b0, SZ_W, 1'b0, 32'h7C, 32'h0, 32'h0, 1'b0);
    drain();

    // Byte loads with sign and zero extension, back to back after a store.
    issue("st w 08",    1'b1, SZ_W, 1'b0, 32'h08, 32'h80FF7F01, 32'h0, 1'b0);
    issue("ld bs 08",   1'b0, SZ_B, 1'b0, 32'h08, 32'h0, 32'h00000001, 1'b0);
    issue("ld bs 09",   1'b0, SZ_B, 1'b0, 32'h09, 32'h0, 32'h0000007F, 1'b0);
    issue("ld bs 0a",   1'b0, SZ_B, 1'b0, 32'h0A, 32'h0, 32'hFFFFFFFF, 1'b0);
    issue("ld bs 0b",   1'b0, SZ_B, 1'b0, 32'h0B, 32'h0, 32'hFFFFFF80, 1'b0);
    issue("ld bu 0b",   1'b0, SZ_B, 1'b1, 32'h0B, 32'h0, 32'h00000080, 1'b0);
    drain();

    // Half store merging into an existing word.
    issue("st w 10",    1'b1, SZ_W, 1'b0, 32'h10, 32'h11223344, 32'h0, 1'b0);
    issue("st h 12",    1'b1, SZ_H, 1'b0, 32'h12, 32'h0000BEEF, 32'h0, 1'b0);
    issue("ld w 10",    1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'hBEEF3344, 1'b0);
    issue("ld hs 12",   1'b0, SZ_H, 1'b0, 32'h12, 32'h0, 32'hFFFFBEEF, 1'b0);
    issue("ld hu 12",   1'b0, SZ_H, 1'b1, 32'h12, 32'h0, 32'h0000BEEF, 1'b0);
    issue("ld hs 10",   1'b0, SZ_H, 1'b0, 32'h10, 32'h0, 32'h00003344, 1'b0);
    issue("st b 0d",    1'b1, SZ_B, 1'b0, 32'h0D, 32'h123456AB, 32'h0, 1'b0);
    issue("ld w 0c",    1'b0, SZ_W, 1'b0, 32'h0C, 32'h0, 32'h0000AB00, 1'b0);
    drain();

    // Faults: error response, zero data, memory untouched.
    issue("st w 04",    1'b1, SZ_W, 1'b0, 32'h04, 32'hCAFEF00D, 32'h0, 1'b0);
    issue("st w 06 mis",1'b1, SZ_W, 1'b0, 32'h06, 32'hFFFFFFFF, 32'h0, 1'b1);
    issue("ld h 03 mis",1'b0, SZ_H, 1'b0, 32'h03, 32'h0, 32'h0, 1'b1);
    issue("ld h 09 mis",1'b0, SZ_H, 1'b0, 32'h09, 32'h0, 32'h0, 1'b1);
    issue("ld sz3 04",  1'b0, SZ_R, 1'b0, 32'h04, 32'h0, 32'h0, 1'b1);
    issue("st sz3 04",  1'b1, SZ_R, 1'b0, 32'h04, 32'h0, 32'h0, 1'b1);
    issue("st w 80 oor",1'b1, SZ_W, 1'b0, 32'h80, 32'hDEADBEEF, 32'h0, 1'b1);
    issue("st w 84 oor",1'b1, SZ_W, 1'b0, 32'h84, 32'h00000000, 32'h0, 1'b1);
    issue("ld w 88 oor",1'b0, SZ_W, 1'b0, 32'h88, 32'h0, 32'h0, 1'b1);
    issue("ld w 04 kept",1'b0, SZ_W, 1'b0, 32'h04, 32'h0, 32'hCAFEF00D, 1'b0);
    issue("ld w 00 kept",1'b0, SZ_W, 1'b0, 32'h00, 32'h0, 32'h00000000, 1'b0);
    drain();

    // Read-after-write on consecutive edges.
    issue("st w 20",    1'b1, SZ_W, 1'b0, 32'h20, 32'h12345678, 32'h0, 1'b0);
    issue("ld w 20",    1'b0, SZ_W, 1'b0, 32'h20, 32'h0, 32'h12345678, 1'b0);
    drain();

    // Reset with loads in flight: nothing emerges afterwards, array re-cleared.
    issue("ld w 08 f",  1'b0, SZ_W, 1'b0, 32'h08, 32'h0, 32'h0, 1'b0);
    issue("ld w 10 f",  1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0);
    rst = 1'b1;
    req_valid = 1'b0;
    exp_q.delete(); exp_err_q.delete(); exp_acc_q.delete(); exp_tag_q.delete();
    o1_d.delete(); o1_e.delete(); o1_c.delete();
    o2_d.delete(); o2_e.delete(); o2_c.delete();
    step();
    check("mid reset rsp_valid lat1", 32'(rsp_valid1), 32'd0);
    check("mid reset rsp_valid lat2", 32'(rsp_valid2), 32'd0);
    check("mid reset ready", 32'(ready1), 32'd0);
    step();
    rst = 1'b0;
    wait_ready();
    check("no rsp after reset lat1", 32'(o1_d.size()), 32'd0);
    check("no rsp after reset lat2", 32'(o2_d.size()), 32'd0);
    for (int i = 0; i < 32; i++) begin
      issue($sformatf("ld w %02h swept", i * 4), 1'b0, SZ_W, 1'b0, 32'(i * 4),
            32'h0, 32'h0, 1'b0);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
